sprite_line_fetcher: RTL and testbench

- Read-side initiator for the single-port 4096x8 sprite ROMs (64x64 tank sprites, 8-bit colour index).
- Once per video line, fetches the sprite row for the *next* line into a ping-pong line buffer, applying tank rotation during addressing.
- During the current line, streams pixels against hcount to the VGA compositor.
- Sits between the sprite ROM port and the pixel mux.

---
 rtl/sprite_line_fetcher.sv | 206 ++++++++++++++++++++
 tb/tb_sprite_line_fetcher.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_fetcher.sv
// sprite_line_fetcher: fetches next line's sprite row from ROM into a
// ping-pong line buffer (with rotation) and streams it against hcount.
module sprite_line_fetcher #(
  parameter int SPRITE_W     = 64,
  parameter int SPRITE_H     = 64,
  parameter int ADDR_W       = 12,
  parameter int PIX_W        = 8,
  parameter int HCOORD_W     = 11,
  parameter int VCOORD_W     = 10,
  parameter int READ_LATENCY = 1,
  parameter int TRANSPARENT  = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                line_start,
  input  logic [VCOORD_W-1:0] next_vcount,
  input  logic [HCOORD_W-1:0] hcount,
  input  logic                sprite_en,
  input  logic [HCOORD_W-1:0] sprite_x,
  input  logic [VCOORD_W-1:0] sprite_y,
  input  logic [1:0]          rotation,
  output logic [ADDR_W-1:0]   rom_address,
  output logic                rom_chipselect,
  input  logic [PIX_W-1:0]    rom_readdata,
  output logic                pixel_valid,
  output logic [PIX_W-1:0]    pixel_data,
  output logic                busy,
  output logic                overrun
);

  localparam int CW = $clog2(SPRITE_W);
  localparam int RW = $clog2(SPRITE_H);
  localparam int DW = (READ_LATENCY > 1) ?
                      $clog2(READ_LATENCY) : 1;
  localparam logic [CW-1:0] LAST_COL =
    CW'(SPRITE_W - 1);
  localparam logic [DW-1:0] LAST_DRN =
    DW'(READ_LATENCY - 1);
  localparam logic [VCOORD_W:0] ROWS =
    (VCOORD_W + 1)'(SPRITE_H);
  localparam logic [HCOORD_W:0] COLS =
    (HCOORD_W + 1)'(SPRITE_W);
  localparam logic [PIX_W-1:0] TRANSP =
    PIX_W'(TRANSPARENT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                r_disp_sel;
  logic [1:0]          r_hit;
  logic [HCOORD_W-1:0] r_x [2];
  logic [RW-1:0]       r_row;
  logic [1:0]          r_rot;
  logic [CW-1:0]       r_col;
  logic [DW-1:0]       r_dcnt;
  logic                r_overrun;
  logic [READ_LATENCY-1:0] r_pv;
  logic [CW-1:0]       r_pc [READ_LATENCY];
  logic [PIX_W-1:0]    r_buf [2][SPRITE_W];
  logic                r_pix_valid;
  logic [PIX_W-1:0]    r_pix_data;

  logic [VCOORD_W:0]   w_row;
  logic                w_row_hit;
  logic                w_busy;
  logic                w_fbank;
  logic [HCOORD_W:0]   w_rel;
  logic                w_rel_in;
  logic [PIX_W-1:0]    w_pix;
  logic                w_pvalid;

  assign w_row     = {1'b0, next_vcount}
                   - {1'b0, sprite_y};
  assign w_row_hit = sprite_en & ~w_row[VCOORD_W]
                   & (w_row < ROWS);
  assign w_busy    = (r_state != S_IDLE);
  assign w_fbank   = ~r_disp_sel;

  // fetch state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // next state: a line start always relaunches
  always_comb begin
    w_state_nxt = r_state;
    if (line_start) begin
      w_state_nxt = w_row_hit ? S_FETCH : S_IDLE;
    end else begin
      unique case (r_state)
        S_FETCH:
          if (r_col == LAST_COL)
            w_state_nxt = S_DRAIN;
        S_DRAIN:
          if (r_dcnt == LAST_DRN)
            w_state_nxt = S_IDLE;
        default: ;
      endcase
    end
  end

  // ROM request outputs with rotation mapping
  always_comb begin
    rom_address    = '0;
    rom_chipselect = 1'b0;
    busy           = w_busy;
    if (r_state == S_FETCH) begin
      rom_chipselect = 1'b1;
      unique case (r_rot)
        2'd0: rom_address = {r_row, r_col};
        2'd1: rom_address = {~r_col, r_row};
        2'd2: rom_address = {~r_row, ~r_col};
        2'd3: rom_address = {r_col, ~r_row};
      endcase
    end
  end

  // bank swap, launch latch, column/drain counters, sticky overrun
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_disp_sel <= 1'b0;
      r_hit      <= '0;
      r_x[0]     <= '0;
      r_x[1]     <= '0;
      r_row      <= '0;
      r_rot      <= '0;
      r_col      <= '0;
      r_dcnt     <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_dcnt <= (r_state == S_DRAIN) ?
                r_dcnt + 1'b1 : '0;
      if (line_start) begin
        r_disp_sel        <= ~r_disp_sel;
        r_x[r_disp_sel]   <= sprite_x;
        r_hit[r_disp_sel] <= 1'b0;
        r_row             <= w_row[RW-1:0];
        r_rot             <= rotation;
        r_col             <= '0;
        if (w_busy) begin
          r_hit[w_fbank] <= 1'b0;
          r_overrun      <= 1'b1;
        end
      end else begin
        if (r_state == S_FETCH)
          r_col <= r_col + 1'b1;
        if (r_state == S_DRAIN &&
            r_dcnt == LAST_DRN)
          r_hit[w_fbank] <= 1'b1;
      end
    end
  end

  // column/valid delay pipe matching ROM latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pv <= '0;
      for (int i = 0; i < READ_LATENCY; i++)
        r_pc[i] <= '0;
    end else begin
      r_pv[0] <= (r_state == S_FETCH) & ~line_start;
      r_pc[0] <= r_col;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1] & ~line_start;
        r_pc[i] <= r_pc[i-1];
      end
    end
  end

  // capture ROM data into the fetch bank
  always_ff @(posedge clk) begin
    if (r_pv[READ_LATENCY-1] && !line_start)
      r_buf[w_fbank][r_pc[READ_LATENCY-1]]
        <= rom_readdata;
  end

  assign w_rel    = {1'b0, hcount}
                  - {1'b0, r_x[r_disp_sel]};
  assign w_rel_in = ~w_rel[HCOORD_W] & (w_rel < COLS);
  assign w_pix    = r_buf[r_disp_sel][w_rel[CW-1:0]];
  assign w_pvalid = r_hit[r_disp_sel] & w_rel_in
                  & (w_pix != TRANSP);

  // registered pixel stream from the display bank
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pix_valid <= 1'b0;
      r_pix_data  <= '0;
    end else begin
      r_pix_valid <= w_pvalid;
      r_pix_data  <= w_pvalid ? w_pix : '0;
    end
  end

  assign pixel_valid = r_pix_valid;
  assign pixel_data  = r_pix_data;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// tb_sprite_line_fetcher: scoreboard bench for sprite_line_fetcher
// with a registered ROM model (data = addr[7:0], one forced zero).
module tb_sprite_line_fetcher;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        line_start = 1'b0;
  logic [9:0]  next_vcount = '0;
  logic [10:0] hcount = '0;
  logic        sprite_en = 1'b0;
  logic [10:0] sprite_x = '0;
  logic [9:0]  sprite_y = 10'd100;
  logic [1:0]  rotation = '0;
  logic [11:0] rom_address;
  logic        rom_chipselect;
  logic [7:0]  rom_readdata = '0;
  logic        pixel_valid;
  logic [7:0]  pixel_data;
  logic        busy;
  logic        overrun;

  sprite_line_fetcher dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .line_start    (line_start),
    .next_vcount   (next_vcount),
    .hcount        (hcount),
    .sprite_en     (sprite_en),
    .sprite_x      (sprite_x),
    .sprite_y      (sprite_y),
    .rotation      (rotation),
    .rom_address   (rom_address),
    .rom_chipselect(rom_chipselect),
    .rom_readdata  (rom_readdata),
    .pixel_valid   (pixel_valid),
    .pixel_data    (pixel_data),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  int zaddr = -1;

  function automatic logic [7:0] rom_fn(input int a);
    if (a == zaddr) return 8'd0;
    return 8'(a & 255);
  endfunction

  always @(posedge clk)
    rom_readdata <= rom_fn(int'(rom_address));

  function automatic int exp_addr(input int rot,
                                  input int row,
                                  input int col);
    case (rot)
      0:       return row * 64 + col;
      1:       return (63 - col) * 64 + row;
      2:       return (63 - row) * 64 + (63 - col);
      default: return col * 64 + (63 - row);
    endcase
  endfunction

  logic [8:0] pq[$];
  int         aq[$];
  bit         d_hit = 0;
  int         d_x = 0;
  logic [7:0] d_pix [64];
  bit         p_cand = 0;
  int         p_x = 0;
  logic [7:0] p_pix [64];
  int         age = 0;
  bit         m_ovr = 0;
  int         bcnt = 0;

  task automatic cyc(input bit ls, input int hc);
    int rel;
    int row;
    int a;
    logic [8:0] e;
    line_start = ls;
    hcount = 11'(hc);
    rel = (hc & 2047) - d_x;
    e = '0;
    if (d_hit && rel >= 0 && rel < 64)
      if (d_pix[rel] != 8'd0)
        e = {1'b1, d_pix[rel]};
    pq.push_back(e);
    if (ls) begin
      if (p_cand && age < 65) m_ovr = 1;
      d_hit = p_cand && age >= 65;
      d_x = p_x;
      d_pix = p_pix;
      row = int'(next_vcount) - int'(sprite_y);
      p_cand = sprite_en && row >= 0 && row < 64;
      p_x = int'(sprite_x);
      aq.delete();
      if (p_cand)
        for (int c = 0; c < 64; c++) begin
          a = exp_addr(int'(rotation), row, c);
          aq.push_back(a);
          p_pix[c] = rom_fn(a);
        end
      age = -1;
      bcnt = 0;
    end
    @(posedge clk);
    #1;
    age++;
    line_start = 1'b0;
    if (busy) bcnt++;
    e = pq.pop_front();
    chk("pixel", {pixel_valid, pixel_data}, e);
    if (aq.size() == 0)
      chk("rom_cs_idle", rom_chipselect, 0);
    else if (rom_chipselect)
      chk("rom_addr", rom_address, aq.pop_front());
    chk("overrun", overrun, m_ovr);
  endtask

  task automatic run_line(input int len, input int hbase);
    bit cand;
    int exp_b;
    int exp_left;
    cyc(1, hbase);
    cand = p_cand;
    for (int i = 1; i < len; i++) cyc(0, hbase + i);
    exp_b = cand ? ((len < 65) ? len : 65) : 0;
    exp_left = cand ? ((len < 64) ? 64 - len : 0) : 0;
    chk("busy_cycles", bcnt, exp_b);
    chk("addr_left", aq.size(), exp_left);
  endtask

  task automatic set_sp(input bit en, input int rot,
                        input int vc, input int x);
    sprite_en = en;
    rotation = 2'(rot);
    next_vcount = 10'(vc);
    sprite_x = 11'(x);
  endtask

  initial begin
    #12;
    chk("rst_addr", rom_address, 0);
    chk("rst_cs", rom_chipselect, 0);
    chk("rst_pv", pixel_valid, 0);
    chk("rst_pd", pixel_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    set_sp(1, 0, 105, 200);  run_line(80, 0);
    set_sp(1, 1, 105, 200);  run_line(80, 192);
    set_sp(1, 2, 105, 300);  run_line(80, 192);
    set_sp(1, 3, 105, 100);  run_line(80, 292);
    set_sp(1, 0, 99, 100);   run_line(80, 92);
    set_sp(1, 0, 164, 100);  run_line(80, 0);
    set_sp(1, 0, 163, 2000); run_line(80, 0);
    zaddr = 5 * 64 + 10;
    set_sp(1, 0, 105, 50);   run_line(80, 1992);
    set_sp(0, 0, 105, 50);   run_line(80, 42);

    set_sp(1, 0, 105, 200);  run_line(40, 0);
    set_sp(1, 0, 106, 200);  run_line(80, 192);
    set_sp(0, 0, 106, 200);  run_line(80, 192);

    set_sp(1, 0, 105, 200);  run_line(31, 0);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cs", rom_chipselect, 0);
    chk("mid_rst_pv", pixel_valid, 0);
    chk("mid_rst_ovr", overrun, 0);
    @(negedge clk);
    reset_n = 1'b1;
    d_hit = 0;
    p_cand = 0;
    m_ovr = 0;
    aq.delete();
    pq.delete();
    @(posedge clk);
    #1;
    set_sp(1, 0, 105, 200);  run_line(80, 192);
    set_sp(0, 0, 105, 200);  run_line(80, 192);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
